// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings, FSM states and
// request legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  function automatic logic is_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Size is carried in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte mask generation, plus
// load lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rdata >> {i_off, 3'b000});
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wmask = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_wmask = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_wmask = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one byte/half/word access in flight against a variable-latency
// word memory. Optional misalignment trap enabled by LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_t        r_state;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [ADDR_W-3:0] r_addr;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;

  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ldata;
  logic              w_trap;
  logic              w_timeout;

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_rdata),
    .o_wmask  (w_wmask),
    .o_wdata  (w_wdata),
    .o_rdata  (w_ldata)
  );

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    w_trap = is_misaligned(req_funct3, req_addr[1:0]);
`else
    w_trap = 1'b0;
`endif
  end

  // The count is checked before its increment, so mem_req is up exactly TIMEOUT_CYCLES cycles.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Memory strobes decode straight from state so an async reset drops them at once.
  assign req_ready = (r_state == IDLE);
  assign mem_req   = (r_state == ACCESS);
  assign mem_we    = mem_req && r_is_store;
  assign mem_wmask = mem_we ? w_wmask : 4'b0000;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_wdata;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_cnt      <= '0;
      r_rsp_data <= 32'd0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_off      <= req_addr[1:0];
            r_addr     <= req_addr[ADDR_W-1:2];
            r_wdata    <= req_wdata;
            r_cnt      <= '0;
            if (!is_legal(req_is_store, req_funct3) || w_trap) begin
              r_rsp_data <= 32'd0;
              r_rsp_err  <= 1'b1;
              r_state    <= RESP;
            end else begin
              r_state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack) begin
            r_rsp_data <= r_is_store ? 32'd0 : w_ldata;
            r_rsp_err  <= 1'b0;
            r_state    <= RESP;
          end else if (w_timeout) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b1;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4); honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    chk("issue_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hs_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'hFFFF_FFFF);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_we_mask"}, {27'd0, mem_we, mem_wmask}, 32'd0);
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    handshake();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0; rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_ctrl", {26'd0, mem_req, mem_we, rsp_valid, rsp_err, 2'b00}, 32'd0);
    chk("rst_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // SB 0x103, ack two cycles after mem_req
    issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    chk("sb_mem_req", {31'd0, mem_req}, 32'd1);
    chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
    chk("sb_mem_addr", {2'b00, mem_addr}, 32'h40);
    chk("sb_wmask", {28'd0, mem_wmask}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_req_ready", {31'd0, req_ready}, 32'd0);
    step();
    chk("sb_hold_req", {31'd0, mem_req}, 32'd1);
    chk("sb_hold_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sb_rsp_data", rsp_data, 32'd0);
    chk("sb_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("sb_mem_req_off", {31'd0, mem_req}, 32'd0);
    handshake();

    // SH 0x102 and SW 0x104, SB offset 0
    issue(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD);
    chk("sh_wmask", {28'd0, mem_wmask}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    handshake();
    issue(1'b1, 3'b010, 32'h0000_0104, 32'h1234_ABCD);
    chk("sw_wmask", {28'd0, mem_wmask}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'h1234_ABCD);
    chk("sw_mem_addr", {2'b00, mem_addr}, 32'h41);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    handshake();
    issue(1'b1, 3'b000, 32'h0000_0100, 32'h0000_0042);
    chk("sb0_wmask", {28'd0, mem_wmask}, 32'h1);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    handshake();

    // Load extraction
    load("lb",  3'b000, 32'h0000_0101, 32'h1234_8000, 32'hFFFF_FF80);
    load("lbu", 3'b100, 32'h0000_0101, 32'h1234_8000, 32'h0000_0080);
    load("lh",  3'b001, 32'h0000_0102, 32'h8000_1234, 32'hFFFF_8000);
    load("lhu", 3'b101, 32'h0000_0102, 32'h8000_1234, 32'h0000_8000);
    load("lb3", 3'b000, 32'h0000_0103, 32'h7F00_0000, 32'h0000_007F);
    load("lh0", 3'b001, 32'h0000_0100, 32'h8000_1234, 32'h0000_1234);

    // LW 0x200, ack same cycle, writeback stalls 3 cycles
    issue(1'b0, 3'b010, 32'h0000_0200, 32'd0);
    chk("lw_mem_addr", {2'b00, mem_addr}, 32'h80);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("lw_stall_data", rsp_data, 32'hDEAD_BEEF);
      chk("lw_stall_req_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    chk("lw_last_data", rsp_data, 32'hDEAD_BEEF);
    handshake();

    // Illegal funct3
    issue(1'b0, 3'b011, 32'h0000_0100, 32'd0);
    chk("ill_ld_mem_req", {31'd0, mem_req}, 32'd0);
    chk("ill_ld_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ill_ld_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_ld_data", rsp_data, 32'd0);
    handshake();
    issue(1'b1, 3'b100, 32'h0000_0100, 32'd0);
    chk("ill_st_mem_req", {31'd0, mem_req}, 32'd0);
    chk("ill_st_err", {31'd0, rsp_err}, 32'd1);
    handshake();

    // Timeout after 4 cycles with no ack
    issue(1'b0, 3'b010, 32'h0000_0300, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req_hi", {31'd0, mem_req}, 32'd1);
      step();
    end
    chk("to_mem_req_lo", {31'd0, mem_req}, 32'd0);
    chk("to_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_err", {31'd0, rsp_err}, 32'd1);
    chk("to_data", rsp_data, 32'd0);
    handshake();

    // Ack on the timeout cycle wins
    issue(1'b0, 3'b010, 32'h0000_0300, 32'd0);
    step(); step(); step();
    chk("race_mem_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 1'b0;
    chk("race_err", {31'd0, rsp_err}, 32'd0);
    chk("race_data", rsp_data, 32'h0BAD_F00D);
    handshake();

    // Reset mid-access; later ack ignored
    issue(1'b0, 3'b010, 32'h0000_0200, 32'd0);
    chk("rstmid_pre", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_req_ready2", {31'd0, req_ready}, 32'd1);
    chk("rstmid_mem_req2", {31'd0, mem_req}, 32'd0);

    // Misaligned word
    issue(1'b0, 3'b010, 32'h0000_0202, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mis_err", {31'd0, rsp_err}, 32'd1);
    chk("mis_data", rsp_data, 32'd0);
`else
    chk("mis_mem_req", {31'd0, mem_req}, 32'd1);
    chk("mis_mem_addr", {2'b00, mem_addr}, 32'h80);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    chk("mis_err", {31'd0, rsp_err}, 32'd0);
    chk("mis_data", rsp_data, 32'h5555_AAAA);
`endif
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory stage of the RV32I core, directly downstream of the ALU. Takes the ALU sum as the effective address and rs2 as store data, then runs one byte/half/word access on a word-addressed data memory with variable latency. Returns sign- or zero-extended load data to writeback through a valid/ready handshake. One request is in flight at a time.

Parameters:
ADDR_W, 32, byte-address width; mem_addr is ADDR_W-2 bits
TIMEOUT_CYCLES, 16, cycles in ACCESS without mem_ack before an error response; 0 disables the timeout

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents a request
req_ready  out  1  LSU can accept a request
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_W  effective byte address (ALU Result)
req_wdata  in  32  rs2 value
mem_req  out  1  memory access strobe, held until mem_ack
mem_we  out  1  write enable
mem_addr  out  ADDR_W-2  word address, req_addr[ADDR_W-1:2]
mem_wmask  out  4  byte-lane write mask
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid in the same cycle
mem_rdata  in  32  read word
rsp_valid  out  1  response to writeback
rsp_ready  in  1  writeback accepts the response
rsp_data  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  illegal funct3, timeout, or misaligned access (see macro)

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1. mem_req, mem_we, mem_wmask, rsp_valid and rsp_err are 0. mem_addr, mem_wdata and rsp_data are 0. Timeout counter is 0. Reset drops mem_req immediately, even mid-access; any later mem_ack is ignored.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, capture is_store, funct3, addr and wdata.
  - Legal request: go to ACCESS.
  - Illegal request: go straight to RESP with rsp_err=1. Illegal means load funct3 in {011,110,111}, or store funct3 other than {000,001,010}.
- ACCESS: mem_req=1, and mem_we/mem_addr/mem_wmask/mem_wdata stay stable until mem_ack. req_ready=0. The counter increments each cycle.
  - mem_ack: latch the formatted data, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to RESP with rsp_err=1.
  - Ack and timeout in the same cycle: the ack wins.
- RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_ready. On rsp_ready, go to IDLE; req_ready rises the next cycle.
- Minimum latency: accept at cycle 0, mem_req at cycle 1, ack at cycle 1, rsp_valid at cycle 2. A new request can be accepted every 3 cycles at best.
- Store formatting, with o = req_addr[1:0]:
  - SB: wdata[7:0] replicated to all 4 lanes, wmask = 4'b0001<<o.
  - SH: wdata[15:0] replicated twice, wmask = 4'b0011<<(2*o[1]).
  - SW: wdata unchanged, wmask = 4'b1111.
- Load extraction:
  - LB/LBU: byte at lane o, sign/zero extended.
  - LH/LHU: half at o[1], sign/zero extended.
  - LW: full word.
  - mem_we=0 and wmask=0 for loads.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, skip ACCESS and go to RESP with rsp_err=1 and rsp_data=0. No mem_req is issued.
- Undefined: misalignment is never an error. Half accesses ignore addr[0]; word accesses ignore addr[1:0].

Decomposition:
- lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - lsu_state_t enum {IDLE, ACCESS, RESP}
  - function is_legal(is_store, funct3)
- One sub-module, lsu_align: purely combinational. Store lane replication and mask generation, plus load lane select and extension. It is shared by both paths and unit-testable alone.

Test Plan:
- SB addr=0x103, wdata=0x000000A5, ack after 2 cycles -> mem_addr=0x40, wmask=1000, wdata=0xA5A5A5A5, rsp_data=0, rsp_err=0.
- LB addr=0x101, rdata=0x12348000; LBU same; LH addr=0x102, rdata=0x80001234 -> LB gives 0xFFFFFF80, LBU gives 0x00000080, LH gives 0xFFFF8000.
- LW addr=0x200, ack same cycle as mem_req, rsp_ready held low for 3 cycles -> rsp_valid at cycle 2, data stable for all 3 cycles, req_ready=0 until after the rsp_ready handshake.
- Load funct3=011 -> no mem_req, rsp_err=1; with TIMEOUT_CYCLES=4 and no ack -> mem_req for exactly 4 cycles, then rsp_err=1.
- rst_n pulsed low during ACCESS -> mem_req=0 immediately; an ack after reset is ignored, req_ready=1.
- LW addr=0x202: with LSU_MISALIGN_TRAP_EN -> rsp_err=1 and no mem_req; without it -> mem_addr=0x80, rsp_err=0.
